fft32_top: RTL and testbench

- Top-level 32-point radix-2 decimation-in-time FFT engine for the TinyFPGA FFT design.
- Samples are loaded into an internal working RAM, then transformed in place on `start`.
- The result spectrum is streamed out in natural bin order, followed by a finish pulse.
- Single clock domain.

---
 rtl/fft32_top.sv | 190 +++++++++++++++++++
 tb/tb_fft32_top.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fft32_top.sv
// 32-point radix-2 DIT FFT: samples loaded in bit-reversed order, transformed in place
// with 4-cycle butterflies, then streamed out in natural bin order.
module fft32_top #(
  parameter int N  = 32,
  parameter int DW = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        in_we,
  input  logic [4:0]  in_addr,
  input  logic [15:0] in_data,
  output logic        busy,
  output logic        out_valid,
  output logic [4:0]  out_addr,
  output logic [15:0] out_data,
  output logic        fft_finish
);

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0] ram [0:N-1];
  logic [2:0]  stage;
  logic [3:0]  bfly;
  logic [1:0]  phase;
  logic [4:0]  rd_addr;
  logic [15:0] a_reg, b_reg;
  logic [3:0]  k_reg;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // W^k = round(127*cos), round(-127*sin) for angle 2*pi*k/32
  function automatic logic signed [7:0] tw_re(input logic [3:0] k);
    case (k)
      4'd0:  return 8'sd127;   4'd1:  return 8'sd125;
      4'd2:  return 8'sd117;   4'd3:  return 8'sd106;
      4'd4:  return 8'sd90;    4'd5:  return 8'sd71;
      4'd6:  return 8'sd49;    4'd7:  return 8'sd25;
      4'd8:  return 8'sd0;     4'd9:  return -8'sd25;
      4'd10: return -8'sd49;   4'd11: return -8'sd71;
      4'd12: return -8'sd90;   4'd13: return -8'sd106;
      4'd14: return -8'sd117;  default: return -8'sd125;
    endcase
  endfunction

  function automatic logic signed [7:0] tw_im(input logic [3:0] k);
    case (k)
      4'd0:  return 8'sd0;     4'd1:  return -8'sd25;
      4'd2:  return -8'sd49;   4'd3:  return -8'sd71;
      4'd4:  return -8'sd90;   4'd5:  return -8'sd106;
      4'd6:  return -8'sd117;  4'd7:  return -8'sd125;
      4'd8:  return -8'sd127;  4'd9:  return -8'sd125;
      4'd10: return -8'sd117;  4'd11: return -8'sd106;
      4'd12: return -8'sd90;   4'd13: return -8'sd71;
      4'd14: return -8'sd49;   default: return -8'sd25;
    endcase
  endfunction

  // Butterfly addressing: A = group*2h + pos, B = A + h, k = pos*(16/h)
  logic [4:0] span, pos, idx_a, idx_b, k_full;
  assign span   = 5'd1 << stage;
  assign pos    = {1'b0, bfly} & (span - 5'd1);
  assign idx_a  = (({1'b0, bfly} >> stage) << (stage + 3'd1)) | pos;
  assign idx_b  = idx_a + span;
  assign k_full = pos << (3'd4 - stage);

  logic signed [7:0]  ar, ai, br, bi, wr, wi, tr, ti;
  logic signed [15:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [16:0] sum_r, sum_i;
  logic signed [8:0]  sa_r, sa_i, sb_r, sb_i;
  logic [15:0]        a_new, b_new;

  assign ar = a_reg[15:8];
  assign ai = a_reg[7:0];
  assign br = b_reg[15:8];
  assign bi = b_reg[7:0];
  assign wr = tw_re(k_reg);
  assign wi = tw_im(k_reg);

  assign p_rr  = 16'(br) * 16'(wr);
  assign p_ii  = 16'(bi) * 16'(wi);
  assign p_ri  = 16'(br) * 16'(wi);
  assign p_ir  = 16'(bi) * 16'(wr);
  assign sum_r = 17'(p_rr) - 17'(p_ii);
  assign sum_i = 17'(p_ri) + 17'(p_ir);

  // k=0 and k=8 bypass the multiplier so trivial rotations stay exact
  always_comb begin
    tr = sum_r[14:7];
    ti = sum_i[14:7];
    if (k_reg == 4'd0) begin
      tr = br;
      ti = bi;
    end else if (k_reg == 4'd8) begin
      tr = bi;
      ti = -br;
    end
  end

  assign sa_r  = 9'(ar) + 9'(tr);
  assign sa_i  = 9'(ai) + 9'(ti);
  assign sb_r  = 9'(ar) - 9'(tr);
  assign sb_i  = 9'(ai) - 9'(ti);
  assign a_new = {sa_r[8:1], sa_i[8:1]};
  assign b_new = {sb_r[8:1], sb_i[8:1]};

  logic accept, last_bfly;
  assign accept    = (state == IDLE) && start;
  assign last_bfly = (stage == 3'd4) && (bfly == 4'd15) && (phase == 2'd3);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COMPUTE;
      COMPUTE: if (last_bfly) state_nxt = OUTPUT;
      OUTPUT:  if (rd_addr == 5'd31) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phases: 0 fetch A, 1 fetch B, 2 store A', 3 store B'
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage <= '0;
      bfly  <= '0;
      phase <= '0;
      a_reg <= '0;
      b_reg <= '0;
      k_reg <= '0;
    end else if (accept) begin
      stage <= '0;
      bfly  <= '0;
      phase <= '0;
    end else if (state == COMPUTE) begin
      phase <= phase + 2'd1;
      if (phase == 2'd0) a_reg <= ram[idx_a];
      if (phase == 2'd1) begin
        b_reg <= ram[idx_b];
        k_reg <= k_full[3:0];
      end
      if (phase == 2'd3) begin
        bfly <= bfly + 4'd1;
        if (bfly == 4'd15) stage <= stage + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == IDLE && in_we)
      ram[bitrev5(in_addr)] <= in_data;
    else if (state == COMPUTE && phase == 2'd2)
      ram[idx_a] <= a_new;
    else if (state == COMPUTE && phase == 2'd3)
      ram[idx_b] <= b_new;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      fft_finish <= 1'b0;
      rd_addr    <= '0;
    end else begin
      out_valid  <= (state == OUTPUT);
      fft_finish <= (state == DONE);
      if (accept) begin
        busy    <= 1'b1;
        rd_addr <= '0;
      end
      if (state == DONE) busy <= 1'b0;
      if (state == OUTPUT) begin
        out_addr <= rd_addr;
        out_data <= ram[rd_addr];
        rd_addr  <= rd_addr + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft32_top.sv
// Bench for fft32_top: loads sample sets, queues the expected spectrum, and checks
// data, bin order, latency and finish/busy behaviour as words stream out.
module tb_fft32_top;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start, in_we;
  logic [4:0]  in_addr;
  logic [15:0] in_data;
  logic        busy, out_valid, fft_finish;
  logic [4:0]  out_addr;
  logic [15:0] out_data;

  fft32_top dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .in_we(in_we), .in_addr(in_addr),
    .in_data(in_data), .busy(busy), .out_valid(out_valid), .out_addr(out_addr),
    .out_data(out_data), .fft_finish(fft_finish)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  int          tol = 0;
  logic [15:0] exp_q[$];
  logic [15:0] samples[32];

  task automatic check_val(input string tag, input int got, input int exp, input int tol_v);
    n_checks++;
    if (got > exp + tol_v || got < exp - tol_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol_v);
    end
  endtask

  function automatic int s8(input logic [7:0] v);
    return int'(signed'(v));
  endfunction

  // Loads samples[], starts (optionally together with the last write), then checks
  // the whole output stream against exp_q.
  task automatic run_fft(input string tag, input bit merge, input bit disturb);
    int          t0, idx;
    bit          done;
    logic [15:0] e;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      in_we   = 1'b1;
      in_addr = 5'(i);
      in_data = samples[i];
      start   = merge && (i == 31);
    end
    if (!merge) begin
      @(negedge CLK);
      in_we = 1'b0;
      start = 1'b1;
    end
    @(posedge CLK);
    #1;
    t0    = cyc;
    start = 1'b0;
    in_we = 1'b0;
    idx   = 0;
    done  = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge CLK);
      if (disturb && cyc >= t0 + 5 && cyc < t0 + 40) begin
        start   = 1'b1;
        in_we   = 1'b1;
        in_addr = 5'($urandom_range(0, 31));
        in_data = 16'($urandom_range(0, 65535));
      end else begin
        start = 1'b0;
        in_we = 1'b0;
      end
      if (c == 0) check_val({tag, "_busy_start"}, int'(busy), 1, 0);
      if (out_valid) begin
        if (idx == 0) check_val({tag, "_first_valid_lat"}, cyc - t0, 321, 0);
        check_val($sformatf("%s_addr%0d", tag, idx), int'(out_addr), idx % 32, 0);
        check_val($sformatf("%s_busy%0d", tag, idx), int'(busy), 1, 0);
        if (exp_q.size() == 0) begin
          check_val({tag, "_queue_underrun"}, 0, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val($sformatf("%s_re%0d", tag, idx), s8(out_data[15:8]), s8(e[15:8]), tol);
          check_val($sformatf("%s_im%0d", tag, idx), s8(out_data[7:0]), s8(e[7:0]), tol);
        end
        idx++;
      end
      if (fft_finish) begin
        check_val({tag, "_finish_lat"}, cyc - t0, 353, 0);
        check_val({tag, "_words"}, idx, 32, 0);
        check_val({tag, "_busy_at_finish"}, int'(busy), 0, 0);
        done = 1'b1;
      end
    end
    if (!done) check_val({tag, "_timeout"}, 0, 1, 0);
    start = 1'b0;
    in_we = 1'b0;
    @(negedge CLK);
    check_val({tag, "_finish_pulse"}, int'(fft_finish), 0, 0);
    check_val({tag, "_valid_after"}, int'(out_valid), 0, 0);
    check_val({tag, "_queue_left"}, exp_q.size(), 0, 0);
  endtask

  task automatic setup_dc();
    tol = 0;
    for (int i = 0; i < 32; i++) begin
      samples[i] = 16'h4000;
      exp_q.push_back(i == 0 ? 16'h4000 : 16'h0000);
    end
  endtask

  task automatic setup_tone();
    real xr[32], xi[32], th, sr, si;
    tol = 3;
    for (int n = 0; n < 32; n++) begin
      th    = 2.0 * 3.14159265358979 * n / 32.0;
      xr[n] = real'(int'(64.0 * $cos(th)));
      xi[n] = real'(int'(64.0 * $sin(th)));
      samples[n] = {8'(int'(xr[n])), 8'(int'(xi[n]))};
    end
    for (int m = 0; m < 32; m++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 32; n++) begin
        th = 2.0 * 3.14159265358979 * m * n / 32.0;
        sr = sr + xr[n] * $cos(th) + xi[n] * $sin(th);
        si = si + xi[n] * $cos(th) - xr[n] * $sin(th);
      end
      exp_q.push_back({8'(int'(sr / 32.0)), 8'(int'(si / 32.0))});
    end
  endtask

  initial begin
    RST_N   = 1'b0;
    start   = 1'b0;
    in_we   = 1'b0;
    in_addr = '0;
    in_data = '0;
    repeat (3) @(negedge CLK);
    check_val("rst_busy", int'(busy), 0, 0);
    check_val("rst_valid", int'(out_valid), 0, 0);
    check_val("rst_finish", int'(fft_finish), 0, 0);
    check_val("rst_addr", int'(out_addr), 0, 0);
    check_val("rst_data", int'(out_data), 0, 0);
    RST_N = 1'b1;

    setup_dc();
    run_fft("dc", 1'b0, 1'b0);

    setup_dc();
    run_fft("dc_b2b_disturb", 1'b0, 1'b1);

    tol = 0;
    for (int i = 0; i < 32; i++) begin
      samples[i] = (i % 2 == 0) ? 16'h4000 : 16'hC000;
      exp_q.push_back(i == 16 ? 16'h4000 : 16'h0000);
    end
    run_fft("alt_merge", 1'b1, 1'b0);

    tol = 1;
    for (int i = 0; i < 32; i++) begin
      samples[i] = (i == 0) ? 16'h4000 : 16'h0000;
      exp_q.push_back(16'h0200);
    end
    run_fft("impulse", 1'b0, 1'b0);

    setup_tone();
    run_fft("tone", 1'b0, 1'b0);

    // Abort a transform with reset mid-compute; no output must follow.
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      in_we   = 1'b1;
      in_addr = 5'(i);
      in_data = 16'h2A15;
    end
    @(negedge CLK);
    in_we = 1'b0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (100) @(negedge CLK);
    check_val("abort_busy_before", int'(busy), 1, 0);
    RST_N = 1'b0;
    #1;
    check_val("abort_busy", int'(busy), 0, 0);
    check_val("abort_valid", int'(out_valid), 0, 0);
    check_val("abort_finish", int'(fft_finish), 0, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (300) begin
      @(negedge CLK);
      if (out_valid || fft_finish || busy) check_val("abort_quiet", 1, 0, 0);
    end

    setup_dc();
    run_fft("dc_after_rst", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
